// File: rtl/zframebuffer_scanout.sv
// Framebuffer scanout: prefetches RGB565 quads from SDRAM into a small FIFO and
// delivers one pixel per display strobe, substituting a fill colour on underflow.
module zframebuffer_scanout #(
  parameter int          FRAME_PIXELS    = 384000,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iFrame_Start,
  input  logic        iPixel_Req,
  output logic [23:0] oSDRAM_Rd_Addr,
  output logic        oSDRAM_Rd_Req,
  input  logic        iSDRAM_Rd_Done,
  input  logic [15:0] iSDRAM_Data1,
  input  logic [15:0] iSDRAM_Data2,
  input  logic [15:0] iSDRAM_Data3,
  input  logic [15:0] iSDRAM_Data4,
  output logic [15:0] oPixel_Data,
  output logic        oPixel_Valid,
  output logic        oUnderflow,
  output logic        oFrame_Done,
  output logic [1:0]  dbg_state
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [23:0]     LAST_QUAD = 24'(FRAME_PIXELS - 4);
  localparam logic [18:0]     LAST_PIX  = 19'(FRAME_PIXELS - 1);
  localparam logic [CW-1:0]   DEPTH     = CW'(FIFO_DEPTH);

  // Read handshake: oSDRAM_Rd_Req rises with a stable oSDRAM_Rd_Addr and is held
  // until the single-cycle iSDRAM_Rd_Done, which carries the four pixels.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  state_t          state;
  logic [23:0]     rd_addr;
  logic            discard;
  logic [63:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fill_count;
  logic [1:0]      sub;
  logic [18:0]     pix_idx;
  logic            frame_end;
  logic [63:0]     head;
  logic [15:0]     head_pix;
  logic            can_issue;
  logic            push;
  logic            serve;
  logic            starve;
  logic            pop;

  assign dbg_state = state;

  // Outstanding reads are zero outside ISSUE, so only fill_count gates a new issue.
  assign can_issue = en && !iFrame_Start && (fill_count < DEPTH) && (rd_addr <= LAST_QUAD);
  assign push      = (state == ISSUE) && iSDRAM_Rd_Done && !discard && !iFrame_Start;
  assign serve     = en && iPixel_Req && !iFrame_Start;
  assign starve    = (fill_count == '0) || frame_end;
  assign pop       = serve && !starve && (sub == 2'd3);

  always_comb begin
    head     = mem[rd_ptr];
    head_pix = head[15:0];
    case (sub)
      2'd0:    head_pix = head[15:0];
      2'd1:    head_pix = head[31:16];
      2'd2:    head_pix = head[47:32];
      default: head_pix = head[63:48];
    endcase
  end

  // GAP re-enters ISSUE directly so the request is low for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rd_addr        <= '0;
      discard        <= 1'b0;
      oSDRAM_Rd_Req  <= 1'b0;
      oSDRAM_Rd_Addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iFrame_Start) begin
            rd_addr <= '0;
          end else if (can_issue) begin
            state          <= ISSUE;
            oSDRAM_Rd_Req  <= 1'b1;
            oSDRAM_Rd_Addr <= rd_addr;
          end
        end
        ISSUE: begin
          if (iFrame_Start) discard <= 1'b1;
          if (iSDRAM_Rd_Done) begin
            state         <= GAP;
            oSDRAM_Rd_Req <= 1'b0;
            discard       <= 1'b0;
            rd_addr       <= (discard || iFrame_Start) ? 24'd0 : rd_addr + 24'd4;
          end
        end
        GAP: begin
          if (can_issue) begin
            state          <= ISSUE;
            oSDRAM_Rd_Req  <= 1'b1;
            oSDRAM_Rd_Addr <= rd_addr;
          end else begin
            state <= IDLE;
            if (iFrame_Start) rd_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {iSDRAM_Data4, iSDRAM_Data3, iSDRAM_Data2, iSDRAM_Data1};
  end

  // Pixel index advances on underflow too, keeping the raster position aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      sub          <= '0;
      pix_idx      <= '0;
      frame_end    <= 1'b0;
      oPixel_Data  <= '0;
      oPixel_Valid <= 1'b0;
      oUnderflow   <= 1'b0;
      oFrame_Done  <= 1'b0;
    end else begin
      oPixel_Valid <= 1'b0;
      oUnderflow   <= 1'b0;
      oFrame_Done  <= 1'b0;
      if (iFrame_Start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fill_count <= '0;
        sub        <= '0;
        pix_idx    <= '0;
        frame_end  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      fill_count <= fill_count + 1'b1;
        else if (pop && !push) fill_count <= fill_count - 1'b1;
        if (serve) begin
          if (starve) begin
            oPixel_Data <= UNDERFLOW_COLOR;
            oUnderflow  <= 1'b1;
          end else begin
            oPixel_Data  <= head_pix;
            oPixel_Valid <= 1'b1;
            sub          <= sub + 2'd1;
          end
          if (!frame_end) begin
            oFrame_Done <= (pix_idx == LAST_PIX);
            if (pix_idx == LAST_PIX) frame_end <= 1'b1;
            else                     pix_idx   <= pix_idx + 19'd1;
          end
        end
      end
    end
  end

endmodule
